// File: rtl/exec_alu_pipe.sv
// exec_alu_pipe: integer ALU with LATENCY-deep fast path. Mul/div unit is built only with EXEC_ALU_MULDIV_EN.
// Latency: LATENCY cycles on the fast path, XLEN+1 cycles for mul/div. Fast-path throughput is 1 op/cycle.
// Backpressure: oValid&!iReady freezes every stage. A mul/div op blocks input until its result drains.
module exec_alu_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int REGW    = 5
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iFlush,
  input  logic            iValid,
  output logic            oReady,
  input  logic [3:0]      iOp,
  input  logic [XLEN-1:0] iOpA,
  input  logic [XLEN-1:0] iOpB,
  input  logic [REGW-1:0] iRdAddr,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic [REGW-1:0] oRdAddr,
  output logic            oIllegal
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] aluRes;
  logic            aluIll;
  logic            stall, accept, accFast;

  logic            stVld [LATENCY];
  logic [XLEN-1:0] stRes [LATENCY];
  logic [REGW-1:0] stTag [LATENCY];
  logic            stIll [LATENCY];

  assign shamt  = iOpB[SHW-1:0];
  assign stall  = oValid && !iReady;
  assign accept = iValid && oReady;

  always_comb begin
    aluRes = '0;
    aluIll = 1'b0;
    case (iOp)
      4'd0:    aluRes = iOpA + iOpB;
      4'd1:    aluRes = iOpA - iOpB;
      4'd2:    aluRes = iOpA << shamt;
      4'd3:    aluRes = {{(XLEN-1){1'b0}}, ($signed(iOpA) < $signed(iOpB))};
      4'd4:    aluRes = {{(XLEN-1){1'b0}}, (iOpA < iOpB)};
      4'd5:    aluRes = iOpA ^ iOpB;
      4'd6:    aluRes = iOpA >> shamt;
      4'd7:    aluRes = $signed(iOpA) >>> shamt;
      4'd8:    aluRes = iOpA | iOpB;
      4'd9:    aluRes = iOpA & iOpB;
      4'd10:   aluRes = iOpA;
      default: aluIll = 1'b1;
    endcase
  end

  // Result is formed in stage 0; later stages only delay it. Flush wins over stall.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stVld[i] <= 1'b0;
        stRes[i] <= '0;
        stTag[i] <= '0;
        stIll[i] <= 1'b0;
      end
    end else if (iFlush) begin
      for (int i = 0; i < LATENCY; i++) stVld[i] <= 1'b0;
    end else if (!stall) begin
      stVld[0] <= accFast;
      stRes[0] <= aluRes;
      stTag[0] <= iRdAddr;
      stIll[0] <= aluIll;
      for (int i = 1; i < LATENCY; i++) begin
        stVld[i] <= stVld[i-1];
        stRes[i] <= stRes[i-1];
        stTag[i] <= stTag[i-1];
        stIll[i] <= stIll[i-1];
      end
    end
  end

`ifdef EXEC_ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state, stateNext;
  logic            isMd, mdAcc, stagesEmpty;
  logic [XLEN-1:0] mdHi, mdLo, mdB;
  logic [1:0]      mdOp;
  logic [REGW-1:0] mdTag;
  logic [SHW-1:0]  mdCnt;
  logic [XLEN:0]   mulSum, divShift, divDiff;

  always_comb begin
    stagesEmpty = 1'b1;
    for (int i = 0; i < LATENCY; i++) if (stVld[i]) stagesEmpty = 1'b0;
  end

  assign isMd    = (iOp >= 4'd11) && (iOp <= 4'd14);
  // Mul/div may only start into an empty pipe so results stay in order.
  assign oReady  = !iRst && !iFlush && !stall && (state == IDLE) && (!isMd || stagesEmpty);
  assign accFast = accept && !isMd;
  assign mdAcc   = accept && isMd;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (iFlush) stateNext = IDLE;
    else begin
      case (state)
        IDLE:    if (mdAcc) stateNext = RUN;
        RUN:     if (mdCnt == SHW'(XLEN-1)) stateNext = DONE;
        DONE:    if (iReady) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // mdHi:mdLo is product (shift-add) or remainder:quotient (restoring divide).
  assign mulSum   = {1'b0, mdHi} + (mdLo[0] ? {1'b0, mdB} : '0);
  assign divShift = {mdHi, mdLo[XLEN-1]};
  assign divDiff  = divShift - {1'b0, mdB};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mdHi  <= '0;
      mdLo  <= '0;
      mdB   <= '0;
      mdOp  <= '0;
      mdTag <= '0;
      mdCnt <= '0;
    end else if (mdAcc) begin
      mdHi  <= '0;
      mdLo  <= iOpA;
      mdB   <= iOpB;
      mdOp  <= 2'(iOp - 4'd11);
      mdTag <= iRdAddr;
      mdCnt <= '0;
    end else if (state == RUN) begin
      mdCnt <= mdCnt + SHW'(1);
      if (!mdOp[1]) begin
        mdHi <= mulSum[XLEN:1];
        mdLo <= {mulSum[0], mdLo[XLEN-1:1]};
      end else if (!divDiff[XLEN]) begin
        mdHi <= divDiff[XLEN-1:0];
        mdLo <= {mdLo[XLEN-2:0], 1'b1};
      end else begin
        mdHi <= divShift[XLEN-1:0];
        mdLo <= {mdLo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    if (state == DONE) begin
      oValid   = 1'b1;
      oResult  = mdOp[0] ? mdHi : mdLo;
      oRdAddr  = mdTag;
      oIllegal = 1'b0;
    end else begin
      oValid   = stVld[LATENCY-1];
      oResult  = stRes[LATENCY-1];
      oRdAddr  = stTag[LATENCY-1];
      oIllegal = stIll[LATENCY-1];
    end
  end
`else
  assign oReady   = !iRst && !iFlush && !stall;
  assign accFast  = accept;
  assign oValid   = stVld[LATENCY-1];
  assign oResult  = stRes[LATENCY-1];
  assign oRdAddr  = stTag[LATENCY-1];
  assign oIllegal = stIll[LATENCY-1];
`endif

endmodule

// File: tb/tb_exec_alu_pipe.sv
// tb_exec_alu_pipe: directed and randomized checks of exec_alu_pipe against a behavioural model.
// Follows EXEC_ALU_MULDIV_EN in the same way as the design.
module tb_exec_alu_pipe;
  localparam int XLEN    = 32;
  localparam int LATENCY = 2;
  localparam int REGW    = 5;

  logic            iClk = 1'b0;
  logic            iRst, iFlush, iValid, oReady, iReady, oValid, oIllegal;
  logic [3:0]      iOp;
  logic [XLEN-1:0] iOpA, iOpB, oResult;
  logic [REGW-1:0] iRdAddr, oRdAddr;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [REGW-1:0] tag;
    logic            ill;
    int              cyc;
  } rec_t;

  rec_t expQ[$];
  rec_t gotQ[$];
  int   checks = 0, failures = 0, cyc = 0, stallCycles = 0, stallLeak = 0;
  bit   lastAcc;

  exec_alu_pipe #(.XLEN(XLEN), .LATENCY(LATENCY), .REGW(REGW)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iOp(iOp), .iOpA(iOpA), .iOpB(iOpB), .iRdAddr(iRdAddr), .oValid(oValid),
    .iReady(iReady), .oResult(oResult), .oRdAddr(oRdAddr), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  function automatic rec_t model(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [REGW-1:0] tag);
    rec_t r;
    int sh;
    logic [2*XLEN-1:0] prod;
    sh   = int'(b[$clog2(XLEN)-1:0]);
    prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    r.res = '0; r.ill = 1'b0; r.tag = tag; r.cyc = 0;
    case (op)
      4'd0:  r.res = a + b;
      4'd1:  r.res = a - b;
      4'd2:  r.res = a << sh;
      4'd3:  r.res = XLEN'($signed(a) < $signed(b));
      4'd4:  r.res = XLEN'(a < b);
      4'd5:  r.res = a ^ b;
      4'd6:  r.res = a >> sh;
      4'd7:  r.res = (a >> sh) | (a[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0);
      4'd8:  r.res = a | b;
      4'd9:  r.res = a & b;
      4'd10: r.res = a;
`ifdef EXEC_ALU_MULDIV_EN
      4'd11: r.res = prod[XLEN-1:0];
      4'd12: r.res = prod[2*XLEN-1:XLEN];
      4'd13: r.res = (b == 0) ? '1 : a / b;
      4'd14: r.res = (b == 0) ? a : a % b;
`endif
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // One clock: record accepted ops (with model result) and delivered results.
  task automatic tick();
    rec_t r;
    @(negedge iClk);
    lastAcc = iValid && oReady;
    if (lastAcc) begin
      r = model(iOp, iOpA, iOpB, iRdAddr);
      r.cyc = cyc;
      expQ.push_back(r);
    end
    if (oValid && iReady) begin
      r.res = oResult; r.tag = oRdAddr; r.ill = oIllegal; r.cyc = cyc;
      gotQ.push_back(r);
    end
    if (oValid && !iReady) begin
      stallCycles++;
      if (oReady) stallLeak++;
    end
    @(posedge iClk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [REGW-1:0] tag);
    int n = 0;
    iValid = 1'b1; iOp = op; iOpA = a; iOpB = b; iRdAddr = tag;
    do begin tick(); n++; end while (!lastAcc && n < 100);
    iValid = 1'b0;
    checks++;
    if (!lastAcc) begin failures++; $display("FAIL issue_timeout op=%0d accepted=0 required=1", op); end
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    iValid = 1'b0; iReady = 1'b1;
    while (gotQ.size() < expQ.size() && n < maxCycles) begin tick(); n++; end
    repeat (3) tick();
  endtask

  task automatic clearQ();
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic test_reset();
    iRst = 1'b1; iFlush = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iOp = '0; iOpA = '0; iOpB = '0; iRdAddr = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL reset_oValid got=%b exp=0", oValid); end
    checks++; if (oResult !== '0) begin failures++; $display("FAIL reset_oResult got=%h exp=0", oResult); end
    checks++; if (oRdAddr !== '0) begin failures++; $display("FAIL reset_oRdAddr got=%h exp=0", oRdAddr); end
    checks++; if (oIllegal !== 1'b0) begin failures++; $display("FAIL reset_oIllegal got=%b exp=0", oIllegal); end
    checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL reset_oReady got=%b exp=0", oReady); end
    @(posedge iClk); #1;
    iRst = 1'b0;
    @(negedge iClk);
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL release_oReady got=%b exp=1", oReady); end
    @(posedge iClk); #1;
  endtask

  task automatic test_directed();
    logic [3:0]      tOp  [5] = '{4'd7, 4'd3, 4'd4, 4'd15, 4'd13};
    logic [XLEN-1:0] tA   [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'd100};
    logic [XLEN-1:0] tB   [5] = '{32'h24, 32'h1, 32'h1, 32'h5678, 32'd7};
    logic [XLEN-1:0] tRes [5] = '{32'hF800_0000, 32'h1, 32'h0, 32'h0, 32'h0};
    logic            tIll [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef EXEC_ALU_MULDIV_EN
    tOp[4] = 4'd10; tA[4] = 32'hCAFE_F00D; tRes[4] = 32'hCAFE_F00D; tIll[4] = 1'b0;
`endif
    clearQ();
    issue(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd7);
    drain(20);
    checks++;
    if (gotQ.size() != 1) begin failures++; $display("FAIL add_count got=%0d exp=1", gotQ.size()); end
    else begin
      checks++; if (gotQ[0].res !== 32'h0) begin failures++; $display("FAIL add_res got=%h exp=0", gotQ[0].res); end
      checks++; if (gotQ[0].tag !== 5'd7) begin failures++; $display("FAIL add_tag got=%0d exp=7", gotQ[0].tag); end
      checks++; if (gotQ[0].ill !== 1'b0) begin failures++; $display("FAIL add_ill got=%b exp=0", gotQ[0].ill); end
      checks++;
      if (gotQ[0].cyc - expQ[0].cyc != LATENCY) begin
        failures++; $display("FAIL add_latency got=%0d exp=%0d", gotQ[0].cyc - expQ[0].cyc, LATENCY);
      end
    end
    clearQ();
    for (int i = 0; i < 5; i++) issue(tOp[i], tA[i], tB[i], REGW'(i + 1));
    drain(20);
    checks++;
    if (gotQ.size() != 5) begin failures++; $display("FAIL directed_count got=%0d exp=5", gotQ.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gotQ[i].res !== tRes[i] || gotQ[i].ill !== tIll[i] || gotQ[i].tag !== REGW'(i + 1)) begin
          failures++;
          $display("FAIL directed_op%0d got=%h/ill%b/tag%0d exp=%h/ill%b/tag%0d", tOp[i], gotQ[i].res,
                   gotQ[i].ill, gotQ[i].tag, tRes[i], tIll[i], i + 1);
        end
        checks++;
        if (gotQ[i].cyc - expQ[i].cyc != LATENCY) begin
          failures++; $display("FAIL directed_latency%0d got=%0d exp=%0d", i, gotQ[i].cyc - expQ[i].cyc, LATENCY);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, sent = 0;
    clearQ();
    stallCycles = 0; stallLeak = 0;
    while (k < 40 && (sent < 5 || gotQ.size() < 5)) begin
      iValid = (sent < 5);
      iOp = 4'($urandom_range(0, 10)); iOpA = $urandom(); iOpB = $urandom(); iRdAddr = REGW'(sent + 10);
      iReady = !(k >= 3 && k <= 6);
      tick();
      if (lastAcc) sent++;
      k++;
    end
    drain(10);
    checks++;
    if (gotQ.size() != 5 || expQ.size() != 5) begin
      failures++; $display("FAIL b2b_count got=%0d exp=5", gotQ.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gotQ[i].res !== expQ[i].res || gotQ[i].tag !== expQ[i].tag || gotQ[i].ill !== expQ[i].ill) begin
          failures++;
          $display("FAIL b2b_result%0d got=%h/tag%0d exp=%h/tag%0d", i, gotQ[i].res, gotQ[i].tag, expQ[i].res, expQ[i].tag);
        end
      end
      for (int i = 2; i < 5; i++) begin
        checks++;
        if (gotQ[i].cyc - gotQ[i-1].cyc != 1) begin
          failures++; $display("FAIL b2b_throughput%0d gap=%0d exp=1", i, gotQ[i].cyc - gotQ[i-1].cyc);
        end
      end
    end
    checks++; if (stallLeak != 0) begin failures++; $display("FAIL b2b_ready_in_stall got=%0d exp=0", stallLeak); end
    checks++; if (stallCycles != 4) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=4", stallCycles); end
  endtask

  task automatic test_flush();
    clearQ();
    iReady = 1'b1;
    issue(4'd0, 32'd11, 32'd22, 5'd1);
    issue(4'd5, 32'hF0F0, 32'h0FF0, 5'd2);
    iReady = 1'b0; iFlush = 1'b1; iValid = 1'b1; iOp = 4'd0; iRdAddr = 5'd3;
    tick();
    checks++; if (lastAcc !== 1'b0) begin failures++; $display("FAIL flush_accept got=%b exp=0", lastAcc); end
    iFlush = 1'b0; iValid = 1'b0; iReady = 1'b1;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL flush_oValid got=%b exp=0", oValid); end
    repeat (5) tick();
    checks++; if (gotQ.size() != 0) begin failures++; $display("FAIL flush_leak got=%0d exp=0", gotQ.size()); end
    clearQ();
    issue(4'($urandom_range(0, 10)), $urandom(), $urandom(), 5'd9);
    drain(20);
    checks++;
    if (gotQ.size() != 1) begin failures++; $display("FAIL postflush_count got=%0d exp=1", gotQ.size()); end
    else begin
      checks++;
      if (gotQ[0].res !== expQ[0].res || gotQ[0].tag !== 5'd9) begin
        failures++; $display("FAIL postflush_result got=%h/tag%0d exp=%h/tag9", gotQ[0].res, gotQ[0].tag, expQ[0].res);
      end
      checks++;
      if (gotQ[0].cyc - expQ[0].cyc != LATENCY) begin
        failures++; $display("FAIL postflush_latency got=%0d exp=%0d", gotQ[0].cyc - expQ[0].cyc, LATENCY);
      end
    end
`ifdef EXEC_ALU_MULDIV_EN
    clearQ();
    issue(4'd11, 32'd5, 32'd7, 5'd4);
    repeat (5) tick();
    iFlush = 1'b1; tick(); iFlush = 1'b0;
    repeat (40) tick();
    checks++; if (gotQ.size() != 0) begin failures++; $display("FAIL flush_run_leak got=%0d exp=0", gotQ.size()); end
    checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL flush_run_idle got=%b exp=1", oReady); end
    clearQ();
    issue(4'd13, 32'd100, 32'd7, 5'd4);
    iReady = 1'b0;
    repeat (40) tick();
    checks++; if (oValid !== 1'b1) begin failures++; $display("FAIL done_hold got=%b exp=1", oValid); end
    iFlush = 1'b1; tick(); iFlush = 1'b0; iReady = 1'b1;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL flush_done_oValid got=%b exp=0", oValid); end
    repeat (3) tick();
    checks++; if (gotQ.size() != 0) begin failures++; $display("FAIL flush_done_leak got=%0d exp=0", gotQ.size()); end
`endif
  endtask

`ifdef EXEC_ALU_MULDIV_EN
  task automatic test_muldiv();
    logic [3:0]      tOp  [6] = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd13, 4'd14};
    logic [XLEN-1:0] tA   [6] = '{32'h10000, 32'h10000, 32'd100, 32'd100, 32'hDEAD_BEEF, 32'h1234_5678};
    logic [XLEN-1:0] tB   [6] = '{32'h10000, 32'h10000, 32'd7, 32'd7, 32'h0, 32'h0};
    logic [XLEN-1:0] tRes [6] = '{32'h0, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234_5678};
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      bit busyLeak = 0;
      clearQ();
      iReady = 1'b1;
      issue(tOp[i], tA[i], tB[i], REGW'(20 + i));
      while (gotQ.size() == 0 && n < 60) begin
        if (oReady !== 1'b0) busyLeak = 1;
        tick();
        n++;
      end
      checks++;
      if (gotQ.size() != 1) begin failures++; $display("FAIL md%0d_count got=%0d exp=1", i, gotQ.size()); end
      else begin
        checks++;
        if (gotQ[0].res !== tRes[i] || gotQ[0].ill !== 1'b0 || gotQ[0].tag !== REGW'(20 + i)) begin
          failures++; $display("FAIL md%0d_result got=%h/ill%b exp=%h/ill0", i, gotQ[0].res, gotQ[0].ill, tRes[i]);
        end
        checks++;
        if (gotQ[0].cyc - expQ[0].cyc != XLEN + 1) begin
          failures++; $display("FAIL md%0d_latency got=%0d exp=%0d", i, gotQ[0].cyc - expQ[0].cyc, XLEN + 1);
        end
      end
      checks++; if (busyLeak) begin failures++; $display("FAIL md%0d_busy_ready got=1 exp=0", i); end
    end
  endtask
`endif

  task automatic test_random();
    clearQ();
    for (int k = 0; k < 400; k++) begin
      iValid  = ($urandom_range(0, 3) != 0);
      iOp     = ($urandom_range(0, 15) < 2) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      iOpA    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
      iOpB    = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 40)) : $urandom();
      iRdAddr = REGW'($urandom());
      iReady  = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(300);
    checks++;
    if (gotQ.size() != expQ.size()) begin
      failures++; $display("FAIL random_count got=%0d exp=%0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (gotQ[i].res !== expQ[i].res || gotQ[i].tag !== expQ[i].tag || gotQ[i].ill !== expQ[i].ill) begin
        failures++;
        $display("FAIL random_result%0d got=%h/tag%0d/ill%b exp=%h/tag%0d/ill%b", i, gotQ[i].res, gotQ[i].tag,
                 gotQ[i].ill, expQ[i].res, expQ[i].tag, expQ[i].ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
`ifdef EXEC_ALU_MULDIV_EN
    test_muldiv();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
